compressed_stream_packer: RTL and testbench
===========================================

Name: compressed_stream_packer

Overview:
- Sits directly downstream of the eight-lane compression pipeline and consumes its per-beat output: data, 16-bit tag field, byte length and flags.
- Concatenates the variable-length records into a dense byte stream with no gaps.
- Emits the stream as 256-bit AXI-Stream beats with tkeep/tlast.
- Its ready output drives the compressor's wrtEn, so it provides backpressure to the whole pipeline.

Parameters:
- DATA_WIDTH, 32, width of one compression lane in bits.
- NUM_UNITS, 8, number of lanes; beat width W = DATA_WIDTH*NUM_UNITS = 256 bits, B = W/8 = 32 bytes.
- TAG_WIDTH, 2, tag bits per lane; full tag field = TAG_WIDTH*NUM_UNITS = 16 bits (2 bytes).
- LEN_WIDTH, 8, width of the record length field, in bytes.
- TKEEP_WIDTH, 32, tkeep width; must equal B.

Ports:
- clk, input, 1, single clock.
- reset, input, 1, asynchronous active-high reset.
- in_flags, input, TKEEP_WIDTH+4, bit 35 = valid, bits 34:3 = tkeep (ignored), bit 2 = tlast, bit 1 = flag_compression, bit 0 = is_header.
- in_data, input, W, record payload; byte k = in_data[8k+7:8k].
- in_tag, input, TAG_WIDTH*NUM_UNITS, 16-bit tag field.
- in_len, input, LEN_WIDTH, record length in bytes; includes the 2 tag bytes when the record is compressed.
- in_ready, output, 1, packer accepts a record this cycle; drives upstream wrtEn.
- m_tdata, output, W, packed output beat.
- m_tkeep, output, B, byte enables; always contiguous from bit 0.
- m_tvalid, output, 1, output beat valid.
- m_tready, input, 1, downstream accept.
- m_tlast, output, 1, last beat of the packet.
- err, output, 1, sticky length-overflow error.

Behaviour:
- **Record assembly.** An input is taken when in_flags[35] && in_ready.
  - Compressed record (flag_compression=1, is_header=0): bytes are in_tag[7:0], in_tag[15:8], then in_data bytes 0..in_len-3.
  - Otherwise: in_data bytes 0..in_len-1; in_tag is ignored.
- **Length clamp.** If in_len > B+2, the length is clamped to B+2 and err is set. err clears only on reset.
- **Accumulator.** 96-byte buffer acc with fill counter cnt, range 0..65, 7 bits.
  - An accepted record is written at byte offset cnt, then cnt += len.
  - Invariant: cnt < B after each cycle in RUN.
- **Output register.** One output register (m_tdata/m_tkeep/m_tlast/m_tvalid). It counts as free when !m_tvalid || m_tready.
- **State RUN** (reset state). in_ready = output register free.
  - On accept with cnt+len >= B and no tlast: emit acc[0..31] with tkeep=all ones and tlast=0; shift acc down by B; cnt = cnt+len-B.
  - On accept with tlast and cnt+len <= B: emit acc[0..cnt+len-1] with tkeep = (1<<(cnt+len))-1 and tlast=1; cnt=0.
  - On accept with tlast and cnt+len > B: emit the first 32 bytes with tlast=0; cnt = cnt+len-B; go to FLUSH.
  - On accept with cnt+len < B and no tlast: no emission; bytes accumulate.
  - len=0 with tlast=1 and cnt=0: emit one beat with tkeep=0 and tlast=1. This is the zero-length terminator and is allowed.
  - len=0 with tlast=0: no-op.
- **State FLUSH.** in_ready=0. When the output register is free: emit the remaining cnt bytes with partial tkeep and tlast=1; cnt=0; return to RUN.
- **Output hold rule.** While m_tvalid && !m_tready, m_tdata/m_tkeep/m_tlast are held stable and in_ready=0.
- **Latency.** A record that completes a beat appears on m_* in the cycle after acceptance (one register stage).
- **Don't-care bytes.** Bytes beyond tkeep are driven to 0.
- **Reset.** Async reset, mid-packet included, sets: m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, err=0, cnt=0, acc=0, state=RUN. Partial packet data is discarded.
- **Arithmetic.** cnt+len is computed at 8 bits, so no wrap is possible given the clamp. Shifts are byte-granular only.

Test Plan:
- **Uncompressed, exact fill.** 4 records (flag_compression=0, len=32, data bytes = 0x00..0x1F + 32*i), last record with tlast → 4 beats, tkeep=0xFFFFFFFF, identical data, tlast only on beat 4.
- **Compressed, no straddle.** Records with len=10 (tag 0xA1B2, data bytes 1..8) ×3, third with tlast → one beat: tkeep=0x3FFFFFFF, bytes B2 A1 01..08 repeated 3×, tlast=1.
- **Straddle plus FLUSH.** cnt=30, then a record with len=34 and tlast → beat 1 is full with tlast=0; beat 2 has tkeep=0xFFFFFFFF>>0 on 32 bytes (cnt=32) and tlast=1; in_ready=0 for exactly one cycle.
- **Backpressure.** m_tready held low for 5 cycles while a beat is pending → in_ready=0 and m_* stable throughout; with ready high, no bytes are lost or duplicated (checked by byte-scoreboard).
- **Error path.** in_len=40 → err=1; record treated as 34 bytes; err stays 1 until reset.
- **Reset mid-operation.** Reset asserted with cnt=17 and m_tvalid=1 → m_tvalid=0 and cnt=0 immediately (asynchronously); the next packet starts at byte 0.

Source files
------------

// File: rtl/compressed_stream_packer.sv
// compressed_stream_packer: packs variable-length compressor records into dense 256-bit AXI-Stream beats.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   in_flags            - {valid, tkeep(ignored), tlast, flag_compression, is_header}
//   in_data, in_tag     - record payload and 16-bit tag field (tag bytes lead compressed records)
//   in_len              - record length in bytes, clamped to B+2
//   in_ready            - record accepted this cycle when valid; drives upstream wrtEn
//   m_tdata/m_tkeep/m_tvalid/m_tready/m_tlast - AXI-Stream master, one register stage
//   err                 - sticky length-overflow flag
module compressed_stream_packer #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_UNITS   = 8,
    parameter int TAG_WIDTH   = 2,
    parameter int LEN_WIDTH   = 8,
    parameter int TKEEP_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [TKEEP_WIDTH+3:0]           in_flags,
    input  logic [DATA_WIDTH*NUM_UNITS-1:0]  in_data,
    input  logic [TAG_WIDTH*NUM_UNITS-1:0]   in_tag,
    input  logic [LEN_WIDTH-1:0]             in_len,
    output logic                             in_ready,
    output logic [DATA_WIDTH*NUM_UNITS-1:0]  m_tdata,
    output logic [TKEEP_WIDTH-1:0]           m_tkeep,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic                             m_tlast,
    output logic                             err
);
    localparam int W = DATA_WIDTH * NUM_UNITS;
    localparam int B = W / 8;
    localparam int TW = TAG_WIDTH * NUM_UNITS;
    localparam int RECW = W + TW;
    localparam int ACCW = 3 * W;
    localparam logic [7:0] B8 = 8'(B);
    localparam logic [7:0] B8X2 = 8'(2 * B);
    localparam logic [6:0] B7 = 7'(B);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(B + 2);
    localparam logic [B:0] ONE = (B + 1)'(1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t stateQ, stateD;
    logic [ACCW-1:0] accQ, accD, merged;
    logic [6:0] cntQ, cntD;
    logic flushLastQ, flushLastD;
    logic [W-1:0] dataD;
    logic [TKEEP_WIDTH-1:0] keepD;
    logic validD, lastD, errD;
    logic outFree, accept, isComp, lastIn, emitNow, fullFlush;
    logic [LEN_WIDTH-1:0] lenC;
    logic [RECW-1:0] rec;
    logic [7:0] total;
    logic [5:0] emitLen;
    logic unusedFlags;

    assign unusedFlags = ^in_flags[TKEEP_WIDTH+2:3];
    assign outFree = !m_tvalid || m_tready;
    assign in_ready = (stateQ == RUN) && outFree;
    assign accept = in_flags[TKEEP_WIDTH+3] && in_ready;
    assign isComp = in_flags[1] && !in_flags[0];
    assign lastIn = in_flags[2];
    assign lenC = (in_len > LEN_MAX) ? LEN_MAX : in_len;
    // Record bytes beyond the clamped length are zeroed so they can be OR-ed into acc,
    // whose bytes at and above cnt are always kept at zero.
    assign rec = (isComp ? {in_data, in_tag} : RECW'(in_data)) & ~({RECW{1'b1}} << {lenC, 3'b000});
    assign merged = accQ | (ACCW'(rec) << {cntQ, 3'b000});
    assign total = 8'(cntQ) + 8'(lenC);
    // In FLUSH a full beat goes out while more than one beat remains (or for a non-last drain).
    assign fullFlush = (cntQ > B7) || (cntQ == B7 && !flushLastQ);

    always_comb begin
        stateD = stateQ;
        accD = accQ;
        cntD = cntQ;
        flushLastD = flushLastQ;
        validD = m_tvalid && !m_tready;
        dataD = m_tdata;
        keepD = m_tkeep;
        lastD = m_tlast;
        errD = err | (accept && in_len > LEN_MAX);
        emitNow = 1'b0;
        emitLen = '0;
        if (stateQ == RUN) begin
            if (accept && lastIn && total <= B8) begin
                emitNow = 1'b1;
                emitLen = total[5:0];
                dataD = merged[W-1:0];
                lastD = 1'b1;
                accD = '0;
                cntD = '0;
            end else if (accept && (lastIn || total >= B8)) begin
                // A remainder of a full beat or more (non-last) is drained through FLUSH too.
                emitNow = 1'b1;
                emitLen = 6'(B);
                dataD = merged[W-1:0];
                lastD = 1'b0;
                accD = merged >> W;
                cntD = 7'(total - B8);
                flushLastD = lastIn;
                stateD = (lastIn || total >= B8X2) ? FLUSH : RUN;
            end else if (accept) begin
                accD = merged;
                cntD = total[6:0];
            end
        end else if (outFree) begin
            emitNow = 1'b1;
            dataD = accQ[W-1:0];
            emitLen = fullFlush ? 6'(B) : cntQ[5:0];
            lastD = !fullFlush;
            accD = fullFlush ? accQ >> W : '0;
            cntD = fullFlush ? cntQ - B7 : '0;
            stateD = (fullFlush && (flushLastQ || cntQ - B7 >= B7)) ? FLUSH : RUN;
        end
        if (emitNow) begin
            validD = 1'b1;
            keepD = TKEEP_WIDTH'((ONE << emitLen) - ONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= RUN;
            accQ <= '0;
            cntQ <= '0;
            flushLastQ <= 1'b0;
            m_tvalid <= 1'b0;
            m_tdata <= '0;
            m_tkeep <= '0;
            m_tlast <= 1'b0;
            err <= 1'b0;
        end else begin
            stateQ <= stateD;
            accQ <= accD;
            cntQ <= cntD;
            flushLastQ <= flushLastD;
            m_tvalid <= validD;
            m_tdata <= dataD;
            m_tkeep <= keepD;
            m_tlast <= lastD;
            err <= errD;
        end
    end
endmodule

// File: tb/tb_compressed_stream_packer.sv
// tb_compressed_stream_packer: byte-queue model bench for compressed_stream_packer.
module tb_compressed_stream_packer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [35:0] in_flags = '0;
    logic [255:0] in_data = '0;
    logic [15:0] in_tag = '0;
    logic [7:0] in_len = '0;
    logic in_ready, m_tvalid, m_tlast, err;
    logic m_tready = 1'b1;
    logic [255:0] m_tdata;
    logic [31:0] m_tkeep;

    compressed_stream_packer dut (
        .clk(clk), .reset(reset), .in_flags(in_flags), .in_data(in_data), .in_tag(in_tag),
        .in_len(in_len), .in_ready(in_ready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic [31:0] k;
        logic l;
    } beat_t;

    beat_t expQ[$];
    beat_t gotQ[$];
    logic [7:0] pend[$];
    logic errExp = 1'b0;
    int tests = 0;
    int fails = 0;

    task automatic chk(string n, logic [255:0] act, logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    function automatic void emitBeat(int n, logic last);
        beat_t b;
        b.d = '0;
        b.k = '0;
        b.l = last;
        for (int i = 0; i < n; i++) begin
            b.d[8*i+:8] = pend.pop_front();
            b.k[i] = 1'b1;
        end
        expQ.push_back(b);
    endfunction

    // Record bytes go into a per-packet byte queue; beats are cut from it in 32-byte chunks.
    function automatic void modelAccept(logic comp, logic hdr, logic last, int len, logic [15:0] tag, logic [255:0] data);
        int n;
        n = (len > 34) ? 34 : len;
        if (len > 34) errExp = 1'b1;
        for (int j = 0; j < n; j++) begin
            if (comp && !hdr) begin
                if (j == 0) pend.push_back(tag[7:0]);
                else if (j == 1) pend.push_back(tag[15:8]);
                else pend.push_back(data[8*(j-2)+:8]);
            end else begin
                pend.push_back(j < 32 ? data[8*j+:8] : 8'h00);
            end
        end
        if (last) begin
            while (pend.size() > 32) emitBeat(32, 1'b0);
            emitBeat(pend.size(), 1'b1);
        end else begin
            while (pend.size() >= 32) emitBeat(32, 1'b0);
        end
    endfunction

    function automatic logic [255:0] ramp(int base);
        logic [255:0] d;
        for (int k = 0; k < 32; k++) d[8*k+:8] = 8'(base + k);
        return d;
    endfunction

    task automatic send(logic comp, logic hdr, logic last, int len, logic [15:0] tag, logic [255:0] data);
        int t;
        t = 0;
        in_flags = {1'b1, 32'hDEADBEEF, last, comp, hdr};
        in_tag = tag;
        in_data = data;
        in_len = 8'(len);
        @(negedge clk);
        while (!in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready got 0 want 1 within 100 cycles");
            in_flags[35] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            modelAccept(comp, hdr, last, len, tag, data);
            in_flags[35] = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (expQ.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", 256'(expQ.size() == 0), 256'(1));
        @(posedge clk);
        #1;
    endtask

    // Per-cycle checker: err, hold rule, and every handshaked beat against the model.
    logic held = 1'b0;
    beat_t hb;
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 1'b0;
            end else begin
                chk("err", 256'(err), 256'(errExp));
                if (m_tvalid && !m_tready) chk("in_ready_hold", 256'(in_ready), 256'(0));
                if (held && m_tvalid) begin
                    chk("hold_data", m_tdata, hb.d);
                    chk("hold_keep", 256'(m_tkeep), 256'(hb.k));
                    chk("hold_last", 256'(m_tlast), 256'(hb.l));
                end
                held = m_tvalid && !m_tready;
                hb.d = m_tdata;
                hb.k = m_tkeep;
                hb.l = m_tlast;
                if (m_tvalid && m_tready) begin
                    if (expQ.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: got keep %h want no beat", m_tkeep);
                    end else begin
                        b = expQ.pop_front();
                        chk("beat_data", m_tdata, b.d);
                        chk("beat_keep", 256'(m_tkeep), 256'(b.k));
                        chk("beat_last", 256'(m_tlast), 256'(b.l));
                    end
                    gotQ.push_back(hb);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        logic [255:0] d;
        #1;
        chk("rst_tvalid", 256'(m_tvalid), 256'(0));
        chk("rst_tkeep", 256'(m_tkeep), 256'(0));
        chk("rst_tlast", 256'(m_tlast), 256'(0));
        chk("rst_tdata", m_tdata, 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Uncompressed exact fill: four 32-byte records
        g = gotQ.size();
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0, i == 3, 32, 16'h0, ramp(32 * i));
        drain();
        chk("fill_beats", 256'(gotQ.size() - g), 256'(4));
        chk("fill_keep", 256'(gotQ[g+3].k), 256'(32'hFFFFFFFF));
        chk("fill_word", 256'(gotQ[g+3].d[31:0]), 256'(32'h63626160));
        chk("fill_last", 256'({gotQ[g+3].l, gotQ[g+2].l}), 256'(2'b10));

        // Compressed, no straddle: three 10-byte records
        g = gotQ.size();
        d = {256{1'b1}} & {24{8'hEE}};
        for (int k = 0; k < 8; k++) d[8*k+:8] = 8'(k + 1);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, i == 2, 10, 16'hA1B2, d);
        drain();
        chk("comp_beats", 256'(gotQ.size() - g), 256'(1));
        chk("comp_keep", 256'(gotQ[g].k), 256'(32'h3FFFFFFF));
        chk("comp_word0", 256'(gotQ[g].d[31:0]), 256'(32'h0201A1B2));
        chk("comp_top", 256'(gotQ[g].d[255:224]), 256'(32'h00000807));

        // Straddle plus FLUSH: cnt=30, then 34-byte compressed tlast record
        g = gotQ.size();
        send(1'b0, 1'b0, 1'b0, 30, 16'h0, ramp(0));
        send(1'b1, 1'b0, 1'b1, 34, 16'hCDAB, ramp(8'h80));
        @(negedge clk);
        chk("flush_ready0", 256'(in_ready), 256'(0));
        @(negedge clk);
        chk("flush_ready1", 256'(in_ready), 256'(1));
        drain();
        chk("strad_top", 256'(gotQ[g].d[255:224]), 256'(32'hCDAB1D1C));
        chk("strad_keep2", 256'(gotQ[g+1].k), 256'(32'hFFFFFFFF));
        chk("strad_word2", 256'(gotQ[g+1].d[31:0]), 256'(32'h83828180));

        // Zero-length terminator
        g = gotQ.size();
        send(1'b0, 1'b0, 1'b1, 0, 16'h0, ramp(5));
        drain();
        chk("zero_keep", 256'(gotQ[g].k), 256'(0));
        chk("zero_last", 256'(gotQ[g].l), 256'(1));

        // Mixed packet: header record, non-last drain past two beats, len-0 no-op
        send(1'b1, 1'b1, 1'b0, 12, 16'h7777, ramp(8'h10));
        send(1'b0, 1'b0, 1'b0, 0, 16'h0, ramp(0));
        send(1'b0, 1'b0, 1'b0, 19, 16'h0, ramp(8'h30));
        send(1'b1, 1'b0, 1'b0, 34, 16'h5566, ramp(8'h60));
        send(1'b1, 1'b0, 1'b1, 3, 16'h8899, ramp(8'hA0));
        drain();

        // Backpressure: one beat held for 5 cycles while the next record waits
        m_tready = 1'b0;
        send(1'b0, 1'b0, 1'b0, 32, 16'h0, ramp(8'hC0));
        fork
            send(1'b0, 1'b0, 1'b1, 32, 16'h0, ramp(8'h20));
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_ready", 256'(in_ready), 256'(0));
                    chk("bp_valid", 256'(m_tvalid), 256'(1));
                end
                @(posedge clk);
                #1 m_tready = 1'b1;
            end
        join
        drain();

        // Error path: in_len=40 clamps to 34 and sets sticky err
        g = gotQ.size();
        send(1'b1, 1'b0, 1'b1, 40, 16'h1234, ramp(8'h40));
        drain();
        chk("err_set", 256'(err), 256'(1));
        chk("err_keep2", 256'(gotQ[g+1].k), 256'(32'h3));
        chk("err_word2", 256'(gotQ[g+1].d[31:0]), 256'(32'h00005F5E));
        send(1'b0, 1'b0, 1'b1, 5, 16'h0, ramp(1));
        drain();
        chk("err_sticky", 256'(err), 256'(1));

        // Reset mid-operation: cnt=17 with a beat held on the output
        send(1'b0, 1'b0, 1'b0, 15, 16'h0, ramp(8'h01));
        send(1'b1, 1'b0, 1'b0, 34, 16'hEEFF, ramp(8'h50));
        m_tready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 256'(m_tvalid), 256'(1));
        #2;
        expQ.delete();
        pend.delete();
        errExp = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_tvalid", 256'(m_tvalid), 256'(0));
        chk("async_tkeep", 256'(m_tkeep), 256'(0));
        chk("async_err", 256'(err), 256'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_tready = 1'b1;
        g = gotQ.size();
        send(1'b0, 1'b0, 1'b1, 4, 16'h0, ramp(8'hD0));
        drain();
        chk("post_rst_keep", 256'(gotQ[g].k), 256'(32'hF));
        chk("post_rst_word", 256'(gotQ[g].d[31:0]), 256'(32'hD3D2D1D0));

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
